// File: rtl/wshb_arb_pkg.sv
// Shared types and defaults for the two-master Wishbone arbiter.
package wshb_arb_pkg;

  // Default number of terminated transfers a master may take while the other waits.
  localparam int unsigned MAX_GRANT_DEFAULT = 64;

  // Default Wishbone address and data widths.
  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_DW = 32;

  // Arbiter ownership states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GNT_VGA  = 2'd1,
    ST_GNT_MIRE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wshb_if.sv
// Classic Wishbone B4 bundle; "_ms" flows master->slave, "_sm" flows slave->master.
interface wshb_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_ms;
  logic [DW-1:0]   dat_sm;
  logic            we;
  logic [DW/8-1:0] sel;
  logic            stb;
  logic            cyc;
  logic            ack;
  logic            err;
  logic [2:0]      cti;
  logic [1:0]      bte;

  modport master (
    output adr, dat_ms, we, sel, stb, cyc, cti, bte,
    input  dat_sm, ack, err
  );

  modport slave (
    input  adr, dat_ms, we, sel, stb, cyc, cti, bte,
    output dat_sm, ack, err
  );

endinterface

// File: rtl/wshb_arbiter.sv
// Two-master Wishbone arbiter (VGA reader, MIRE writer) in front of one SDRAM port.
// Ownership is a registered FSM; the bus is muxed from the registered state only,
// so a request never reaches the SDRAM port combinationally.
module wshb_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int unsigned MAX_GRANT = MAX_GRANT_DEFAULT,
  parameter bit          VGA_PRIO  = 1'b1
) (
  input  logic   clk,
  input  logic   rst,
  wshb_if.slave  wshb_ifs_vga,
  wshb_if.slave  wshb_ifs_mire,
  wshb_if.master wshb_ifm,
  output logic   grant_vga,
  output logic   grant_mire
);

  localparam int unsigned       CNT_W    = $clog2(MAX_GRANT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_GRANT - 1);

  arb_state_e       state_q, state_d;
  arb_state_e       other_st;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vga_req, mire_req;
  logic             own_req, other_req;
  logic             owner_done;
  logic             resp_en;

  assign vga_req  = wshb_ifs_vga.cyc;
  assign mire_req = wshb_ifs_mire.cyc;

  // Owner/challenger view of the requests, so both grant states share one rule set.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    own_req   = 1'b0;
    other_req = 1'b0;
    other_st  = ST_IDLE;
    case (state_q)
      ST_GNT_VGA: begin
        own_req   = vga_req;
        other_req = mire_req;
        other_st  = ST_GNT_MIRE;
      end
      ST_GNT_MIRE: begin
        own_req   = mire_req;
        other_req = vga_req;
        other_st  = ST_GNT_VGA;
      end
      default: ;
    endcase
  end

  // A transfer of the owner ends on either ack or err.
  assign owner_done = (state_q != ST_IDLE) && (wshb_ifm.ack || wshb_ifm.err);

  // Next owner and transfer count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (vga_req && (VGA_PRIO || !mire_req)) state_d = ST_GNT_VGA;
        else if (mire_req)                      state_d = ST_GNT_MIRE;
      end
      ST_GNT_VGA, ST_GNT_MIRE: begin
        if (!own_req) begin
          // Owner released the bus: hand over directly or fall back to idle.
          state_d = other_req ? other_st : ST_IDLE;
          cnt_d   = '0;
        end else if (owner_done) begin
          if (cnt_q == CNT_LAST) begin
            // Quota used up: yield if the other master waits, otherwise start a fresh quota.
            cnt_d = '0;
            if (other_req) state_d = other_st;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_vga  = (state_q == ST_GNT_VGA);
  assign grant_mire = (state_q == ST_GNT_MIRE);

  // Master-side request mux, selected by the registered owner; idle drives all zeros.
  always_comb begin
    wshb_ifm.adr    = '0;
    wshb_ifm.dat_ms = '0;
    wshb_ifm.we     = 1'b0;
    wshb_ifm.sel    = '0;
    wshb_ifm.stb    = 1'b0;
    wshb_ifm.cyc    = 1'b0;
    wshb_ifm.cti    = '0;
    wshb_ifm.bte    = '0;
    case (state_q)
      ST_GNT_VGA: begin
        wshb_ifm.adr    = wshb_ifs_vga.adr;
        wshb_ifm.dat_ms = wshb_ifs_vga.dat_ms;
        wshb_ifm.we     = wshb_ifs_vga.we;
        wshb_ifm.sel    = wshb_ifs_vga.sel;
        wshb_ifm.stb    = wshb_ifs_vga.stb;
        wshb_ifm.cyc    = wshb_ifs_vga.cyc;
        wshb_ifm.cti    = wshb_ifs_vga.cti;
        wshb_ifm.bte    = wshb_ifs_vga.bte;
      end
      ST_GNT_MIRE: begin
        wshb_ifm.adr    = wshb_ifs_mire.adr;
        wshb_ifm.dat_ms = wshb_ifs_mire.dat_ms;
        wshb_ifm.we     = wshb_ifs_mire.we;
        wshb_ifm.sel    = wshb_ifs_mire.sel;
        wshb_ifm.stb    = wshb_ifs_mire.stb;
        wshb_ifm.cyc    = wshb_ifs_mire.cyc;
        wshb_ifm.cti    = wshb_ifs_mire.cti;
        wshb_ifm.bte    = wshb_ifs_mire.bte;
      end
      default: ;
    endcase
  end

  // Responses go only to the owner; a reset cycle swallows any in-flight ack/err
  // because the grant it belongs to is being torn down.
  assign resp_en = !rst;

  assign wshb_ifs_vga.ack  = resp_en && grant_vga  && wshb_ifm.ack;
  assign wshb_ifs_vga.err  = resp_en && grant_vga  && wshb_ifm.err;
  assign wshb_ifs_mire.ack = resp_en && grant_mire && wshb_ifm.ack;
  assign wshb_ifs_mire.err = resp_en && grant_mire && wshb_ifm.err;

  assign wshb_ifs_vga.dat_sm  = wshb_ifm.dat_sm;
  assign wshb_ifs_mire.dat_sm = wshb_ifm.dat_sm;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Randomised bench for wshb_arbiter against an ownership/quota reference model.
module tb_wshb_arbiter;

  localparam int MAXG = 4;
  localparam int NONE = 0;
  localparam int VGA  = 1;
  localparam int MIRE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic grant_vga, grant_mire;

  always #5 clk = ~clk;

  wshb_if vga_if ();
  wshb_if mire_if ();
  wshb_if sdram_if ();

  wshb_arbiter #(.MAX_GRANT(MAXG), .VGA_PRIO(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .wshb_ifs_vga (vga_if),
    .wshb_ifs_mire(mire_if),
    .wshb_ifm     (sdram_if),
    .grant_vga    (grant_vga),
    .grant_mire   (grant_mire)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stimulus knobs (percentages).
  int v_want, m_want, ack_pct, err_pct;
  bit force_ack;

  // Reference model: who owns the port and how many transfers it finished in this grant.
  int owner = NONE;
  int served = 0;
  bit model_valid = 1'b0;
  bit v_term_last = 1'b0;
  bit m_term_last = 1'b0;
  int v_done = 0;
  int m_done = 0;

  bit cap_en = 1'b0;
  logic [32:0] cap_q[$];

  function automatic logic [75:0] bus_of(input int who);
    if (who == VGA)
      return {vga_if.cyc, vga_if.stb, vga_if.we, vga_if.sel, vga_if.adr,
              vga_if.dat_ms, vga_if.cti, vga_if.bte};
    if (who == MIRE)
      return {mire_if.cyc, mire_if.stb, mire_if.we, mire_if.sel, mire_if.adr,
              mire_if.dat_ms, mire_if.cti, mire_if.bte};
    return '0;
  endfunction

  function automatic logic [75:0] bus_dut();
    return {sdram_if.cyc, sdram_if.stb, sdram_if.we, sdram_if.sel, sdram_if.adr,
            sdram_if.dat_ms, sdram_if.cti, sdram_if.bte};
  endfunction

  // Masters start a new transfer after a completed one; an owner with an
  // outstanding strobe must hold it.
  task automatic drive_masters();
    bit v_free, m_free;
    if (v_term_last) vga_if.adr = vga_if.adr + 32'd4;
    if (m_term_last) begin
      mire_if.adr    = mire_if.adr + 32'd4;
      mire_if.dat_ms = $urandom;
      mire_if.sel    = 4'($urandom);
      mire_if.cti    = 3'($urandom);
      mire_if.bte    = 2'($urandom);
    end
    v_free = !(owner == VGA && vga_if.cyc && !v_term_last);
    m_free = !(owner == MIRE && mire_if.cyc && !m_term_last);
    if (v_free) begin
      vga_if.cyc = (int'($urandom_range(99)) < v_want);
      vga_if.stb = vga_if.cyc;
    end
    if (m_free) begin
      mire_if.cyc = (int'($urandom_range(99)) < m_want);
      mire_if.stb = mire_if.cyc;
    end
  endtask

  task automatic drive_slave();
    bit busy;
    int r;
    busy = (owner == VGA && vga_if.cyc) || (owner == MIRE && mire_if.cyc);
    r = int'($urandom_range(99));
    sdram_if.ack    = force_ack || (busy && r < ack_pct);
    sdram_if.err    = !sdram_if.ack && busy && (r < ack_pct + err_pct);
    sdram_if.dat_sm = $urandom;
  endtask

  task automatic model_update();
    bit done, v_t, m_t, own_cyc, oth_cyc;
    int other;
    done = sdram_if.ack || sdram_if.err;
    v_t  = !rst && owner == VGA  && vga_if.cyc  && done;
    m_t  = !rst && owner == MIRE && mire_if.cyc && done;
    if (v_t) v_done++;
    if (m_t) m_done++;
    v_term_last = v_t;
    m_term_last = m_t;
    if (rst) begin
      owner = NONE;
      served = 0;
      model_valid = 1'b1;
    end else if (owner == NONE) begin
      served = 0;
      if (vga_if.cyc)       owner = VGA;
      else if (mire_if.cyc) owner = MIRE;
    end else begin
      own_cyc = (owner == VGA) ? vga_if.cyc : mire_if.cyc;
      oth_cyc = (owner == VGA) ? mire_if.cyc : vga_if.cyc;
      other   = (owner == VGA) ? MIRE : VGA;
      if (!own_cyc) begin
        owner  = oth_cyc ? other : NONE;
        served = 0;
      end else if (v_t || m_t) begin
        served++;
        if (served == MAXG) begin
          served = 0;
          if (oth_cyc) owner = other;
        end
      end
    end
  endtask

  task automatic cycle(input bit r);
    @(negedge clk);
    rst = r;
    drive_masters();
    drive_slave();
    #1;
    if (model_valid) begin
      check("grant_vga", grant_vga, owner == VGA);
      check("grant_mire", grant_mire, owner == MIRE);
      check("ifm_bus", bus_dut(), bus_of(owner));
      check("vga_resp", {vga_if.ack, vga_if.err},
            (owner == VGA && !r) ? {sdram_if.ack, sdram_if.err} : 2'b00);
      check("mire_resp", {mire_if.ack, mire_if.err},
            (owner == MIRE && !r) ? {sdram_if.ack, sdram_if.err} : 2'b00);
      check("dat_sm", {vga_if.dat_sm, mire_if.dat_sm}, {2{sdram_if.dat_sm}});
      if (force_ack) check("late_ack", mire_if.ack, 1'b0);
    end
    if (cap_en && sdram_if.cyc && sdram_if.stb && sdram_if.ack)
      cap_q.push_back({sdram_if.we, sdram_if.adr});
    @(posedge clk);
    model_update();
  endtask

  task automatic go_idle();
    v_want = 0; m_want = 0; ack_pct = 100; err_pct = 0;
    repeat (4) cycle(1'b0);
    #2;
    check("idle_reached", {grant_vga, grant_mire}, 2'b00);
  endtask

  task automatic run_until(input int who, input int target);
    int n = 0;
    while (((who == VGA) ? v_done : m_done) < target && n < 64) begin
      cycle(1'b0);
      n++;
    end
    check("budget", n < 64, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur, prev, run;
    vga_if.adr = '0; vga_if.dat_ms = '0; vga_if.we = 1'b0; vga_if.sel = 4'hF;
    vga_if.stb = 1'b0; vga_if.cyc = 1'b0; vga_if.cti = '0; vga_if.bte = '0;
    mire_if.adr = '0; mire_if.dat_ms = '0; mire_if.we = 1'b1; mire_if.sel = 4'hF;
    mire_if.stb = 1'b0; mire_if.cyc = 1'b0; mire_if.cti = '0; mire_if.bte = '0;
    sdram_if.ack = 1'b0; sdram_if.err = 1'b0; sdram_if.dat_sm = '0;
    force_ack = 1'b0;

    // Reset held with both masters requesting.
    v_want = 100; m_want = 100; ack_pct = 0; err_pct = 0;
    repeat (3) begin
      cycle(1'b1);
      #2;
      check("rst_grants", {grant_vga, grant_mire}, 2'b00);
      check("rst_ifm_cyc", sdram_if.cyc, 1'b0);
    end
    cycle(1'b0);
    #2;
    check("first_grant_vga", {grant_vga, grant_mire}, 2'b10);

    // Fairness: both request, slave acks every cycle -> runs of exactly MAXG.
    go_idle();
    v_want = 100; m_want = 100; ack_pct = 100;
    prev = 0; run = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0);
      #2;
      cur = grant_vga ? VGA : (grant_mire ? MIRE : NONE);
      check("fair_busy", cur != NONE, 1'b1);
      if (cur == prev) run++;
      else begin
        if (prev != NONE) check("fair_run", run, MAXG);
        prev = cur;
        run = 1;
      end
    end

    // Solo MIRE writes of 10 words.
    go_idle();
    mire_if.adr = '0;
    m_done = 0;
    cap_q.delete();
    cap_en = 1'b1;
    m_want = 100;
    run_until(MIRE, 10);
    m_want = 0;
    cycle(1'b0);
    cap_en = 1'b0;
    check("solo_count", cap_q.size(), 10);
    for (int i = 0; i < cap_q.size() && i < 10; i++)
      check("solo_word", cap_q[i], {1'b1, 32'(i * 4)});

    // Release: VGA drops after two acks with MIRE idle.
    go_idle();
    v_done = 0;
    v_want = 100;
    run_until(VGA, 2);
    v_want = 0;
    cycle(1'b0);
    #2;
    check("release_idle", {grant_vga, grant_mire}, 2'b00);
    check("release_cyc", sdram_if.cyc, 1'b0);

    // No preemption: VGA at its last transfer, slave stalls, MIRE waits.
    go_idle();
    v_done = 0;
    v_want = 100; m_want = 100;
    run_until(VGA, MAXG - 1);
    ack_pct = 0;
    repeat (5) begin
      cycle(1'b0);
      #2;
      check("nopreempt", {grant_vga, grant_mire}, 2'b10);
    end
    ack_pct = 100;
    cycle(1'b0);
    #2;
    check("handoff", {grant_vga, grant_mire}, 2'b01);

    // Reset while MIRE waits for an ack; the ack lands in the reset cycle.
    go_idle();
    m_want = 100; ack_pct = 0;
    cycle(1'b0);
    cycle(1'b0);
    #2;
    check("mid_owner", {grant_vga, grant_mire}, 2'b01);
    force_ack = 1'b1;
    cycle(1'b1);
    force_ack = 1'b0;
    #2;
    check("mid_rst_grants", {grant_vga, grant_mire}, 2'b00);
    check("mid_rst_cyc", sdram_if.cyc, 1'b0);

    // Random traffic with occasional resets.
    for (int blk = 0; blk < 60; blk++) begin
      v_want  = int'($urandom_range(100, 20));
      m_want  = int'($urandom_range(100, 20));
      ack_pct = int'($urandom_range(95, 10));
      err_pct = int'($urandom_range(15, 0));
      repeat (50) cycle($urandom_range(99) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wshb_arbiter.md
WSHB_ARBITER -- requirements
Module: wshb_arbiter

Interface
REQ-001 Parameter MAX_GRANT, default 64: max acked transfers per grant when the other master is requesting; legal 1..1023.
REQ-002 Parameter VGA_PRIO, default 1: 1 = VGA wins simultaneous requests from IDLE; 0 = MIRE wins.
REQ-003 clk  input  1  Wishbone clock; single clock domain.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 wshb_ifs_vga  wshb_if.slave  interface  port for the VGA frame-buffer reader (read-only master).
REQ-006 wshb_ifs_mire  wshb_if.slave  interface  port for the pattern/image writer master.
REQ-007 wshb_ifm  wshb_if.master  interface  port to the SDRAM controller.
REQ-008 grant_vga  output  1  VGA currently owns the SDRAM port.
REQ-009 grant_mire  output  1  MIRE currently owns the SDRAM port.

Function
REQ-010 FSM states: IDLE, GNT_VGA, GNT_MIRE; state register only, Moore grant outputs.
REQ-011 A master "requests" when its cyc=1.
REQ-012 IDLE: VGA request only -> GNT_VGA; MIRE request only -> GNT_MIRE; both -> per VGA_PRIO; none -> stay IDLE.
REQ-013 Arbitration latency: request sampled at edge N, slave-side cyc/stb asserted in cycle N+1; no combinational path from a request to wshb_ifm.
REQ-014 In GNT_x: owner's adr, dat_ms, we, sel, stb, cyc, cti, bte drive wshb_ifm unchanged (combinational mux on state).
REQ-015 In IDLE: wshb_ifm cyc=0, stb=0, we=0, sel=0, adr=0, dat_ms=0, cti=0, bte=0.
REQ-016 Slave ack, err, dat_sm routed to owner; non-owner sees ack=0, err=0; dat_sm broadcast to both.
REQ-017 Grant counter counts acks of the owner; cleared on every grant change and in IDLE; width clog2(MAX_GRANT+1).
REQ-018 Handoff: on the edge where owner's ack=1 and counter reaches MAX_GRANT-1 and other master requests -> grant other directly (no IDLE cycle).
REQ-019 Counter at limit with other idle: owner keeps grant, counter restarts at 0.
REQ-020 Owner drops cyc: next state = other's GNT if other requests, else IDLE; no pending transfer carried over.
REQ-021 Grant never changes while owner has stb=1 and no ack in that cycle (no mid-transfer preemption).
REQ-022 err counts as a terminated transfer, same as ack, for REQ-017/018.
REQ-023 grant_vga and grant_mire never both 1.

Reset
REQ-024 On rst=1 at an edge: state=IDLE, counter=0, grant_vga=0, grant_mire=0; wshb_ifm outputs per REQ-015 from the next cycle.
REQ-025 Reset mid-transfer aborts the grant; an in-flight ack arriving during reset is not routed.
REQ-026 First grant possible at the first edge after rst deasserts.

Structure
REQ-027 Shared package wshb_arb_pkg holds the state enum type and the MAX_GRANT default constant.
REQ-028 Single module; no sub-module; datapath mux inline.

Verification
REQ-029 Reset: rst=1 for 3 cycles with both cyc=1 -> wshb_ifm.cyc=0, grants 0; first grant_vga=1 one cycle after rst drops (VGA_PRIO=1).
REQ-030 Solo: only MIRE writes 10 words with adr 0x0..0x24 -> all 10 appear at slave in order, we=1, VGA ack stays 0.
REQ-031 Fairness: MAX_GRANT=4, both cyc=1 continuously, slave ack every cycle -> grants alternate after exactly 4 acks, no IDLE cycle between.
REQ-032 Release: VGA owner drops cyc after 2 acks, MIRE idle -> state IDLE next cycle, wshb_ifm.cyc=0.
REQ-033 No preemption: slave holds ack low 5 cycles on VGA stb at limit, MIRE requesting -> grant stays VGA until ack, then switches to MIRE.
REQ-034 Mid-transfer reset: rst pulsed while MIRE stb=1 awaiting ack -> grants 0 next cycle, late ack not seen by MIRE.
